// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Per-channel button synchroniser, debouncer and strobe generator
//             (clean level, press / release strobes, auto-repeat strobes).
//             The release and repeat strobes are named release_pulse and
//             repeat_pulse because "release" and "repeat" are reserved words.
//  Revision : 1.0  initial release
// ============================================================================
module btn_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int REPEAT_DELAY    = 16000000,
  parameter int REPEAT_PERIOD   = 3200000,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  // Counters compare against "terminal minus one" so the accepting edge is
  // the one on which the count would reach its terminal value.
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             REPEAT_EN   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_t;

  // Internal polarity: 1 always means "pressed".
  logic [NUM_BTN-1:0] btn_n;
  assign btn_n = btn ^ {NUM_BTN{BTN_ACTIVE_LOW != 0}};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic             s1;
    logic             s2;
    logic             lvl;
    logic             prs;
    logic             rls;
    logic             rpt;
    logic             rpt_nxt;
    logic [DB_W-1:0]  dcnt;
    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_nxt;
    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic             accept;
    logic             rise;
    logic             fall;

    // A change is taken on the edge where the debounce count would complete.
    assign accept = (s2 != lvl) && (dcnt == DB_LAST);
    assign rise   = accept &  s2;
    assign fall   = accept & ~s2;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn_n[i];
        s2 <= s1;
      end
    end

    // Debounce: count consecutive disagreeing cycles, accept on completion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
      end else begin
        prs <= rise;
        rls <= fall;
        if (s2 == lvl) begin
          dcnt <= '0;
        end else if (accept) begin
          lvl  <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end

    // Auto-repeat state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
        rpt   <= 1'b0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
        rpt   <= rpt_nxt;
      end
    end

    // Auto-repeat next state: a release always wins over a due repeat strobe.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rpt_nxt   = 1'b0;
      case (state)
        RPT_IDLE: begin
          if (rise && REPEAT_EN) begin
            state_nxt = RPT_DELAY;
            rcnt_nxt  = '0;
          end
        end
        RPT_DELAY: begin
          if (fall) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == DELAY_LAST) begin
            state_nxt = RPT_PERIOD;
            rcnt_nxt  = '0;
            rpt_nxt   = 1'b1;
          end else begin
            rcnt_nxt  = rcnt + 1'b1;
          end
        end
        RPT_PERIOD: begin
          if (fall) begin
            state_nxt = RPT_IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == PERIOD_LAST) begin
            rcnt_nxt  = '0;
            rpt_nxt   = 1'b1;
          end else begin
            rcnt_nxt  = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    assign level[i]         = lvl;
    assign press[i]         = prs;
    assign release_pulse[i] = rls;
    assign repeat_pulse[i]  = rpt;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_conditioner
//  Purpose  : Self-checking bench for btn_conditioner (vector table, directed
//             corner sequences and random stimulus against a reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_a, btn_b, btn_c;
  logic [4:0] level_a, press_a, rel_a, rep_a;
  logic [4:0] level_b, press_b, rel_b, rep_b;
  logic [4:0] level_c, press_c, rel_c, rep_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.NUM_BTN(5), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_a), .level(level_a), .press(press_a),
    .release_pulse(rel_a), .repeat_pulse(rep_a));

  btn_conditioner #(.NUM_BTN(5), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn(btn_b), .level(level_b), .press(press_b),
    .release_pulse(rel_b), .repeat_pulse(rep_b));

  btn_conditioner #(.NUM_BTN(5), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0),
                    .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .btn(btn_c), .level(level_c), .press(press_c),
    .release_pulse(rel_c), .repeat_pulse(rep_c));

  // Reference model for dut_a: a change is accepted once the raw value seen
  // two edges earlier has disagreed with the level for DB edges in a row;
  // repeats fire at press + RD + m*RP while the button stays accepted.
  int         run_m [5];
  int         press_at [5];
  logic       h0 [5];
  logic       h1 [5];
  logic       mlvl [5];
  logic       held [5];
  logic       mv;
  int         cyc;
  int         el;
  logic [4:0] e_lvl, e_prs, e_rel, e_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0;
      for (int i = 0; i < 5; i++) begin
        run_m[i] = 0; press_at[i] = 0;
        h0[i] = 1'b0; h1[i] = 1'b0; mlvl[i] = 1'b0; held[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 5; i++) begin
        mv = h1[i];
        h1[i] = h0[i];
        h0[i] = btn_a[i];
        e_prs[i] = 1'b0; e_rel[i] = 1'b0; e_rep[i] = 1'b0;
        if (mv != mlvl[i]) begin
          run_m[i] = run_m[i] + 1;
          if (run_m[i] == DB) begin
            mlvl[i] = mv;
            run_m[i] = 0;
            if (mv) begin
              e_prs[i] = 1'b1; held[i] = 1'b1; press_at[i] = cyc;
            end else begin
              e_rel[i] = 1'b1; held[i] = 1'b0;
            end
          end
        end else begin
          run_m[i] = 0;
        end
        e_lvl[i] = mlvl[i];
        if (held[i] && !e_prs[i]) begin
          el = cyc - press_at[i];
          if (el >= RD && ((el - RD) % RP) == 0) e_rep[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("model", 32'({level_a, press_a, rel_a, rep_a}), 32'({e_lvl, e_prs, e_rel, e_rep}));
  endtask

  typedef struct {
    logic [4:0] btn;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] rpt;
  } vec_t;

  vec_t vecs [28];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int found;
    int cnt;
    int anyrep;
    int remain [5];

    // Clean press/release on channel 0: row r is observed r+1 edges after
    // its input is driven (press at row 5, repeats every 3 from row 15).
    for (int r = 0; r < 28; r++) begin
      vecs[r].btn = (r < 20) ? 5'b00001 : 5'b00000;
      vecs[r].lvl = (r >= 5 && r <= 24) ? 5'b00001 : 5'b00000;
      vecs[r].prs = (r == 5) ? 5'b00001 : 5'b00000;
      vecs[r].rel = (r == 25) ? 5'b00001 : 5'b00000;
      vecs[r].rpt = (r == 15 || r == 18 || r == 21 || r == 24) ? 5'b00001 : 5'b00000;
    end

    rst_n = 1'b0;
    btn_a = 5'b00000;
    btn_b = 5'b11111;
    btn_c = 5'b00000;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_a", 32'({level_a, press_a, rel_a, rep_a}), 32'd0);
    chk("reset_b", 32'({level_b, press_b, rel_b, rep_b}), 32'd0);
    chk("reset_c", 32'({level_c, press_c, rel_c, rep_c}), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    for (int r = 0; r < 28; r++) begin
      btn_a = vecs[r].btn;
      step();
      chk($sformatf("vec%0d", r), 32'({level_a, press_a, rel_a, rep_a}),
          32'({vecs[r].lvl, vecs[r].prs, vecs[r].rel, vecs[r].rpt}));
    end

    // Bounce rejection on channel 1: 3 high, 1 low, repeated.
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      btn_a[1] = (c % 4) != 3;
      step();
      if (level_a[1] || press_a[1] || rel_a[1]) cnt++;
    end
    chk("bounce_quiet", 32'(cnt), 32'd0);
    cnt = 0;
    btn_a[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (press_a[1]) cnt++;
    end
    chk("bounce_one_press", 32'(cnt), 32'd1);
    chk("bounce_level", 32'(level_a[1]), 32'd1);

    // Auto-repeat on channel 2, release strobe landing on P+15.
    btn_a[2] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (press_a[2]) found = 1;
    end
    chk("rpt_press_seen", 32'(found), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("rpt_P+%0d", k), 32'({rel_a[2], rep_a[2]}),
          32'({(k == 15), (k == 10 || k == 13)}));
      if (k == 9) btn_a[2] = 1'b0;
    end

    // Active-low, several channels at once.
    btn_b = 5'b00110;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("al_press_%0d", k), 32'(press_b), (k == 6) ? 32'h19 : 32'h0);
    end
    chk("al_level", 32'(level_b), 32'h19);

    // Repeat disabled.
    btn_c = 5'b10000;
    cnt = 0;
    anyrep = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (press_c[4]) cnt++;
      if (rep_c != 5'b0) anyrep++;
    end
    chk("norpt_press", 32'(cnt), 32'd1);
    chk("norpt_repeat", 32'(anyrep), 32'd0);
    chk("norpt_level", 32'(level_c), 32'h10);

    // Reset in the middle of a debounce, channel 0 already accepted.
    btn_a = 5'b00001;
    repeat (10) step();
    chk("pre_rst_level", 32'(level_a), 32'h01);
    btn_a = 5'b01001;
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'({level_a, press_a, rel_a, rep_a}), 32'd0);
    chk("async_rst_b", 32'({level_b, press_b, rel_b, rep_b}), 32'd0);
    chk("async_rst_c", 32'({level_c, press_c, rel_c, rep_c}), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("rst_press_%0d", k), 32'(press_a), (k == 6) ? 32'h09 : 32'h0);
      chk($sformatf("rst_press_b_%0d", k), 32'(press_b), (k == 6) ? 32'h19 : 32'h0);
    end

    // Random activity on dut_a, checked every cycle by the model.
    for (int i = 0; i < 5; i++) remain[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (remain[i] == 0) begin
          btn_a[i] = ~btn_a[i];
          remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                  : int'($urandom_range(1, 8));
        end else begin
          remain[i] = remain[i] - 1;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage between the raw badge push-buttons and the LED/flag display logic. It synchronises each button to the clock, debounces it, and produces a clean level plus one-cycle press, release and auto-repeat pulses. Downstream display stages use these strobes to step, pause or restart their sequences instead of sampling `btn` directly. The interconnect pass-through of raw `btn` is unaffected.

## Interface

- `NUM_BTN`, 5: number of independent button channels.
- `DEBOUNCE_CYCLES`, 160000: consecutive stable cycles required to accept a change (5 ms at 32 MHz); minimum 1.
- `REPEAT_DELAY`, 16000000: cycles from a press pulse to the first repeat pulse (0.5 s); 0 disables auto-repeat.
- `REPEAT_PERIOD`, 3200000: cycles between subsequent repeat pulses (0.1 s); minimum 1.
- `BTN_ACTIVE_LOW`, 0: 1 inverts raw inputs so that "pressed" is always 1 internally.

- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn`  input  NUM_BTN  raw asynchronous button pins.
- `level`  output  NUM_BTN  debounced pressed state, 1 = pressed.
- `press`  output  NUM_BTN  one-cycle strobe on each accepted press.
- `release`  output  NUM_BTN  one-cycle strobe on each accepted release.
- `repeat`  output  NUM_BTN  one-cycle auto-repeat strobe while held.

## Operation

- Each channel is fully independent; there is no shared state between channels.
- Polarity: `n = btn ^ {NUM_BTN{BTN_ACTIVE_LOW}}`.
- Synchroniser: two flops per bit (`s1`, `s2`), reset to 0.
- Debounce counter per channel, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - If `s2 == level`, the counter clears to 0.
  - Otherwise it increments.
  - When it would reach `DEBOUNCE_CYCLES`, `level` takes `s2` and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and is never accepted.
- Strobes:
  - `press` is asserted (registered) in the same cycle `level` goes 0→1.
  - `release` is asserted in the same cycle `level` goes 1→0.
  - Each strobe is exactly one cycle wide.
- Auto-repeat, per channel, with a repeat counter of width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`:
  - Idle: `level` is 0, or `REPEAT_DELAY` is 0.
  - Delay: entered on `press`; counts `REPEAT_DELAY` cycles.
  - Period: after the first repeat strobe; counts `REPEAT_PERIOD` cycles between strobes.
  - A release in any state returns the channel to Idle immediately. A repeat strobe is never emitted in the cycle `release` fires, or after it.
  - `repeat` never coincides with `press` on the same channel.
- No saturation issues: counters never exceed their terminal value, and any wrap is prevented by the clear-on-terminal rule.

## Timing

- Reset (`rst_n` = 0, asynchronous): `s1`, `s2`, `level`, `press`, `release`, `repeat` and all counters go to 0 immediately.
- After reset deassertion, a button already held is treated as a new press and accepted after the normal latency.
- Reset mid-debounce or mid-repeat discards all progress; no strobe is emitted for the interrupted event.
- Latency from a clean raw edge (set up before clock edge 0) to the `level` change and strobe is `DEBOUNCE_CYCLES + 2` clock edges:
  - 2 edges for the synchroniser.
  - `DEBOUNCE_CYCLES` edges for the debounce count.
- First `repeat` occurs `REPEAT_DELAY` cycles after the `press` cycle; later strobes follow every `REPEAT_PERIOD` cycles.
- Several channels changing in the same cycle produce their strobes in the same cycle.
- Setting `DEBOUNCE_CYCLES = 1` accepts a change one edge after `s2` differs from `level`.

## Test plan

Parameters for all scenarios: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`, `NUM_BTN=5`.

- **Clean press/release:** raise `btn[0]` and hold 20 cycles, then drop it.
  - `level[0]` rises exactly 6 cycles after the raw edge, with `press[0]` high for that single cycle.
  - `level[0]` falls 6 cycles after the drop, with `release[0]` for one cycle.
- **Bounce rejection:** toggle `btn[1]` with high pulses of 3 cycles separated by 1-cycle lows, for 30 cycles.
  - `level[1]` stays 0; no strobes are emitted.
  - Holding high afterwards produces exactly one `press[1]`.
- **Auto-repeat:** hold `btn[2]` with the press strobe at cycle P.
  - `repeat[2]` pulses at P+10, P+13, P+16.
  - Releasing so that `release[2]` occurs at P+15 yields no pulse at P+16 or later.
- **Simultaneous channels with active-low polarity:** with `BTN_ACTIVE_LOW=1`, drive `btn` from 5'b11111 to 5'b00110 at one edge.
  - `press` equals 5'b11001 in a single cycle.
  - `level` equals 5'b11001 thereafter.
- **Reset mid-operation:** assert `rst_n` = 0 while `btn[3]` is held and during the debounce count, then release reset with the button still held.
  - All outputs are 0 asynchronously.
  - `press[3]` fires 6 cycles after reset deassertion.
- **Repeat disabled:** with `REPEAT_DELAY=0`, hold `btn[4]` for 100 cycles.
  - One `press[4]` is emitted; `repeat[4]` stays 0 throughout.
